// File: rtl/boid_xcel_seq.sv
// Sequential boid update: latch a self boid, fold in a neighbour stream, divide the
// visual-range sums by the neighbour count, then steer, speed-limit and emit the new boid.
module boid_xcel_seq #(
   parameter int W       = 32,
   parameter int FRAC    = 16,
   parameter int CTR_W   = 10,
   parameter int X_MAX   = 640,
   parameter int Y_MAX   = 480,
   parameter int MARGIN  = 100,
   parameter int VIS_SQ  = 1600,
   parameter int PROT_SQ = 64,
   parameter int VMIN    = 4,
   parameter int VMAX    = 8,
   parameter logic signed [W-1:0] TURN   = 'h3999,
   parameter logic signed [W-1:0] AVOID  = 'h666,
   parameter logic signed [W-1:0] MATCH  = 'h1666,
   parameter logic signed [W-1:0] CENTER = 'h10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_center_en,
   input  logic                cfg_match_en,
   input  logic                self_valid,
   output logic                self_ready,
   input  logic signed [W-1:0] self_x,
   input  logic signed [W-1:0] self_y,
   input  logic signed [W-1:0] self_vx,
   input  logic signed [W-1:0] self_vy,
   input  logic                nb_valid,
   output logic                nb_ready,
   input  logic                nb_last,
   input  logic signed [W-1:0] nb_x,
   input  logic signed [W-1:0] nb_y,
   input  logic signed [W-1:0] nb_vx,
   input  logic signed [W-1:0] nb_vy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_x,
   output logic signed [W-1:0] out_y,
   output logic signed [W-1:0] out_vx,
   output logic signed [W-1:0] out_vy,
   output logic                busy
);

   localparam int DC_W = $clog2(W);

   localparam logic [2*W:0]        PROT_FX   = (2*W+1)'(PROT_SQ) << FRAC;
   localparam logic [2*W:0]        VIS_FX    = (2*W+1)'(VIS_SQ) << FRAC;
   localparam logic signed [W-1:0] MARGIN_FX = W'(MARGIN) << FRAC;
   localparam logic signed [W-1:0] X_HI_FX   = W'(X_MAX - MARGIN) << FRAC;
   localparam logic signed [W-1:0] Y_HI_FX   = W'(Y_MAX - MARGIN) << FRAC;
   localparam logic [W:0]          VMIN_FX   = (W+1)'(VMIN) << FRAC;
   localparam logic [W:0]          VMAX_FX   = (W+1)'(VMAX) << FRAC;

   typedef enum logic [2:0] {
      S_IDLE, S_ACCUM, S_DIV, S_STEER, S_LIMIT, S_OUT
   } state_t;

   state_t state_reg, state_next;

   // Index order for the four-wide arrays: 0=x, 1=y, 2=vx, 3=vy.
   logic signed [W-1:0] self_reg [4];
   logic signed [W-1:0] sum_reg  [4];
   logic signed [W-1:0] close_x_reg, close_y_reg;
   logic [CTR_W-1:0]    count_reg;
   logic [DC_W-1:0]     div_cnt_reg;
   logic signed [W-1:0] vtx_reg, vty_reg;
   logic signed [W-1:0] out_x_reg, out_y_reg, out_vx_reg, out_vy_reg;

   logic                self_fire, nb_fire;
   logic [3:0][W-1:0]   avg_pk;

   function automatic logic signed [W-1:0] fmul(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
      logic signed [2*W-1:0] p;
      p = a * b;
      return W'(p >>> FRAC);
   endfunction

   function automatic logic [W-1:0] mag_of(input logic signed [W-1:0] v);
      return v[W-1] ? W'(-v) : W'(v);
   endfunction

   // ---------------- control ----------------
   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      self_ready = 1'b0;
      nb_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            self_ready = !reset;
            if (self_valid) state_next = S_ACCUM;
         end
         S_ACCUM: begin
            nb_ready = !reset;
            if (nb_valid && nb_last) state_next = S_DIV;
         end
         S_DIV: begin
            if (count_reg == '0 || div_cnt_reg == DC_W'(W - 1)) state_next = S_STEER;
         end
         S_STEER: state_next = S_LIMIT;
         S_LIMIT: state_next = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign self_fire = self_valid && self_ready;
   assign nb_fire   = nb_valid && nb_ready;
   assign busy      = (state_reg != S_IDLE);

   // ---------------- neighbour classification ----------------
   logic signed [W-1:0]   dx, dy;
   logic signed [2*W-1:0] dx_sq, dy_sq;
   logic [2*W:0]          d_sq;
   logic                  is_prot, is_vis, ctr_full;

   assign dx       = self_reg[0] - nb_x;
   assign dy       = self_reg[1] - nb_y;
   assign dx_sq    = dx * dx;
   assign dy_sq    = dy * dy;
   assign d_sq     = ({1'b0, dx_sq} + {1'b0, dy_sq}) >> FRAC;
   assign is_prot  = d_sq < PROT_FX;
   assign is_vis   = d_sq < VIS_FX;
   assign ctr_full = &count_reg;

   // ---------------- restoring dividers, one bit per cycle, MSB first ----------------
   logic [DC_W-1:0] bit_idx;
   assign bit_idx = DC_W'(W - 1) - div_cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_div
         logic [CTR_W-1:0] rem_reg;
         logic [W-1:0]     quo_reg;
         logic [W-1:0]     mag;
         logic [CTR_W:0]   rem_shift;
         logic [CTR_W-1:0] rem_sub;
         logic             rem_ge;

         assign mag       = mag_of(sum_reg[gi]);
         assign rem_shift = {rem_reg, mag[bit_idx]};
         assign rem_ge    = rem_shift >= {1'b0, count_reg};
         assign rem_sub   = rem_shift[CTR_W-1:0] - count_reg;

         always_ff @(posedge clk) begin
            if (reset || self_fire) begin
               rem_reg <= '0;
               quo_reg <= '0;
            end else if (state_reg == S_DIV && count_reg != '0) begin
               rem_reg <= rem_ge ? rem_sub : rem_shift[CTR_W-1:0];
               quo_reg <= {quo_reg[W-2:0], rem_ge};
            end
         end

         // An empty neighbourhood falls back to the self value so its terms vanish.
         assign avg_pk[gi] = (count_reg == '0) ? self_reg[gi]
                           : (sum_reg[gi][W-1] ? W'(-quo_reg) : quo_reg);
      end
   endgenerate

   // ---------------- steering ----------------
   logic signed [W-1:0] center_f, match_f, turn_x, turn_y, vx_t, vy_t;

   assign center_f = cfg_center_en ? CENTER : '0;
   assign match_f  = cfg_match_en  ? MATCH  : '0;
   assign turn_x   = (self_reg[0] < MARGIN_FX) ? TURN : (self_reg[0] > X_HI_FX) ? -TURN : '0;
   assign turn_y   = (self_reg[1] < MARGIN_FX) ? TURN : (self_reg[1] > Y_HI_FX) ? -TURN : '0;

   assign vx_t = self_reg[2]
               + fmul($signed(avg_pk[0]) - self_reg[0], center_f)
               + fmul($signed(avg_pk[2]) - self_reg[2], match_f)
               + fmul(close_x_reg, AVOID) + turn_x;
   assign vy_t = self_reg[3]
               + fmul($signed(avg_pk[1]) - self_reg[1], center_f)
               + fmul($signed(avg_pk[3]) - self_reg[3], match_f)
               + fmul(close_y_reg, AVOID) + turn_y;

   // ---------------- speed limit (octagonal norm approximation) ----------------
   logic [W-1:0]        abs_x, abs_y, hi_v, lo_v;
   logic [W:0]          speed;
   logic                too_fast, too_slow;
   logic signed [W-1:0] vx_l, vy_l;

   assign abs_x    = mag_of(vtx_reg);
   assign abs_y    = mag_of(vty_reg);
   assign hi_v     = (abs_x >= abs_y) ? abs_x : abs_y;
   assign lo_v     = (abs_x >= abs_y) ? abs_y : abs_x;
   assign speed    = {1'b0, hi_v} + (W+1)'(lo_v >> 2);
   assign too_fast = speed > VMAX_FX;
   assign too_slow = speed < VMIN_FX;
   assign vx_l     = too_fast ? vtx_reg - (vtx_reg >>> 2)
                   : too_slow ? vtx_reg + (vtx_reg >>> 2) : vtx_reg;
   assign vy_l     = too_fast ? vty_reg - (vty_reg >>> 2)
                   : too_slow ? vty_reg + (vty_reg >>> 2) : vty_reg;

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            self_reg[i] <= '0;
            sum_reg[i]  <= '0;
         end
         close_x_reg <= '0;
         close_y_reg <= '0;
         count_reg   <= '0;
         div_cnt_reg <= '0;
         vtx_reg     <= '0;
         vty_reg     <= '0;
         out_x_reg   <= '0;
         out_y_reg   <= '0;
         out_vx_reg  <= '0;
         out_vy_reg  <= '0;
      end else begin
         if (self_fire) begin
            self_reg[0] <= self_x;
            self_reg[1] <= self_y;
            self_reg[2] <= self_vx;
            self_reg[3] <= self_vy;
            for (int i = 0; i < 4; i++) sum_reg[i] <= '0;
            close_x_reg <= '0;
            close_y_reg <= '0;
            count_reg   <= '0;
            div_cnt_reg <= '0;
         end
         if (nb_fire) begin
            if (is_prot) begin
               close_x_reg <= close_x_reg + dx;
               close_y_reg <= close_y_reg + dy;
            end else if (is_vis && !ctr_full) begin
               sum_reg[0] <= sum_reg[0] + nb_x;
               sum_reg[1] <= sum_reg[1] + nb_y;
               sum_reg[2] <= sum_reg[2] + nb_vx;
               sum_reg[3] <= sum_reg[3] + nb_vy;
               count_reg  <= count_reg + CTR_W'(1);
            end
         end
         if (state_reg == S_DIV && count_reg != '0) div_cnt_reg <= div_cnt_reg + DC_W'(1);
         if (state_reg == S_STEER) begin
            vtx_reg <= vx_t;
            vty_reg <= vy_t;
         end
         if (state_reg == S_LIMIT) begin
            out_vx_reg <= vx_l;
            out_vy_reg <= vy_l;
            out_x_reg  <= self_reg[0] + vx_l;
            out_y_reg  <= self_reg[1] + vy_l;
         end
      end
   end

   assign out_x  = out_x_reg;
   assign out_y  = out_y_reg;
   assign out_vx = out_vx_reg;
   assign out_vy = out_vy_reg;

endmodule

// File: tb/tb_boid_xcel_seq.sv
// Bench for boid_xcel_seq: directed table vectors, reset/saturation/backpressure sequences,
// and randomized boids checked against an arithmetic reference model.
module tb_boid_xcel_seq;

   localparam int F       = 65536;
   localparam int W       = 32;
   localparam int TURN    = 'h3999;
   localparam int AVOID   = 'h666;
   localparam int MATCH   = 'h1666;
   localparam int CENTER  = 'h10;

   typedef struct packed {
      logic signed [31:0] x, y, vx, vy;
   } boid_t;

   typedef struct packed {
      boid_t       s;
      logic [3:0]  n;
      boid_t [2:0] nb;
      logic        cen, mat;
      boid_t       exp;
      logic [7:0]  lat;
   } vec_t;

   logic clk = 0, reset = 1, dut_sel = 0;
   logic cfg_center_en = 0, cfg_match_en = 0;
   logic self_valid = 0, nb_valid = 0, nb_last = 0, out_ready = 0;
   logic signed [31:0] self_x = 0, self_y = 0, self_vx = 0, self_vy = 0;
   logic signed [31:0] nb_x = 0, nb_y = 0, nb_vx = 0, nb_vy = 0;

   logic a_self_ready, a_nb_ready, a_out_valid, a_busy;
   logic b_self_ready, b_nb_ready, b_out_valid, b_busy;
   logic signed [31:0] a_out_x, a_out_y, a_out_vx, a_out_vy;
   logic signed [31:0] b_out_x, b_out_y, b_out_vx, b_out_vy;

   logic m_self_ready, m_nb_ready, m_out_valid, m_busy;
   logic signed [31:0] m_out_x, m_out_y, m_out_vx, m_out_vy;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   boid_xcel_seq #(.W(W)) dut_a (
      .clk(clk), .reset(reset), .cfg_center_en(cfg_center_en), .cfg_match_en(cfg_match_en),
      .self_valid(self_valid && !dut_sel), .self_ready(a_self_ready),
      .self_x(self_x), .self_y(self_y), .self_vx(self_vx), .self_vy(self_vy),
      .nb_valid(nb_valid && !dut_sel), .nb_ready(a_nb_ready), .nb_last(nb_last),
      .nb_x(nb_x), .nb_y(nb_y), .nb_vx(nb_vx), .nb_vy(nb_vy),
      .out_valid(a_out_valid), .out_ready(out_ready && !dut_sel),
      .out_x(a_out_x), .out_y(a_out_y), .out_vx(a_out_vx), .out_vy(a_out_vy),
      .busy(a_busy)
   );

   boid_xcel_seq #(.W(W), .CTR_W(2)) dut_b (
      .clk(clk), .reset(reset), .cfg_center_en(cfg_center_en), .cfg_match_en(cfg_match_en),
      .self_valid(self_valid && dut_sel), .self_ready(b_self_ready),
      .self_x(self_x), .self_y(self_y), .self_vx(self_vx), .self_vy(self_vy),
      .nb_valid(nb_valid && dut_sel), .nb_ready(b_nb_ready), .nb_last(nb_last),
      .nb_x(nb_x), .nb_y(nb_y), .nb_vx(nb_vx), .nb_vy(nb_vy),
      .out_valid(b_out_valid), .out_ready(out_ready && dut_sel),
      .out_x(b_out_x), .out_y(b_out_y), .out_vx(b_out_vx), .out_vy(b_out_vy),
      .busy(b_busy)
   );

   assign m_self_ready = dut_sel ? b_self_ready : a_self_ready;
   assign m_nb_ready   = dut_sel ? b_nb_ready   : a_nb_ready;
   assign m_out_valid  = dut_sel ? b_out_valid  : a_out_valid;
   assign m_busy       = dut_sel ? b_busy       : a_busy;
   assign m_out_x      = dut_sel ? b_out_x      : a_out_x;
   assign m_out_y      = dut_sel ? b_out_y      : a_out_y;
   assign m_out_vx     = dut_sel ? b_out_vx     : a_out_vx;
   assign m_out_vy     = dut_sel ? b_out_vy     : a_out_vy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting on the DUT", name);
   endtask

   // ---------------- reference model ----------------
   function automatic int fm(input int a, input int b);
      longint p;
      p = longint'(a) * longint'(b);
      return int'(p >>> 16);
   endfunction

   function automatic int turn_of(input int p, input int lim);
      if (p < 100 * F) return TURN;
      if (p > (lim - 100) * F) return -TURN;
      return 0;
   endfunction

   function automatic boid_t model(input boid_t s, input boid_t nbs[$], input int ctr_max,
                                   input bit cen, input bit mat, output int n);
      int sx, sy, svx, svy, cx, cy, dx, dy, ax, ay, avx, avy, vx, vy, px, py, pvx, pvy;
      longint dsq, mx, mn, sp;
      boid_t r;
      sx = 0; sy = 0; svx = 0; svy = 0; cx = 0; cy = 0; n = 0;
      px = s.x; py = s.y; pvx = s.vx; pvy = s.vy;
      foreach (nbs[i]) begin
         dx  = px - int'(nbs[i].x);
         dy  = py - int'(nbs[i].y);
         dsq = (longint'(dx) * dx + longint'(dy) * dy) >>> 16;
         if (dsq < 64 * longint'(F)) begin
            cx += dx; cy += dy;
         end else if (dsq < 1600 * longint'(F) && n < ctr_max) begin
            sx += nbs[i].x; sy += nbs[i].y; svx += nbs[i].vx; svy += nbs[i].vy;
            n++;
         end
      end
      if (n == 0) begin
         ax = px; ay = py; avx = pvx; avy = pvy;
      end else begin
         ax = sx / n; ay = sy / n; avx = svx / n; avy = svy / n;
      end
      vx = pvx + fm(ax - px, cen ? CENTER : 0) + fm(avx - pvx, mat ? MATCH : 0)
               + fm(cx, AVOID) + turn_of(px, 640);
      vy = pvy + fm(ay - py, cen ? CENTER : 0) + fm(avy - pvy, mat ? MATCH : 0)
               + fm(cy, AVOID) + turn_of(py, 480);
      mx = (vx < 0) ? -longint'(vx) : longint'(vx);
      mn = (vy < 0) ? -longint'(vy) : longint'(vy);
      if (mn > mx) begin sp = mx; mx = mn; mn = sp; end
      sp = mx + mn / 4;
      if (sp > 8 * longint'(F)) begin
         vx = vx - (vx >>> 2); vy = vy - (vy >>> 2);
      end else if (sp < 4 * longint'(F)) begin
         vx = vx + (vx >>> 2); vy = vy + (vy >>> 2);
      end
      r.vx = vx; r.vy = vy; r.x = px + vx; r.y = py + vy;
      return r;
   endfunction

   // ---------------- transaction driver ----------------
   task automatic run_op(input bit sel, input boid_t s, input boid_t nbs[$], input bit cen,
                         input bit mat, input int hold, input bit gaps,
                         output boid_t r, output int lat, output logic sr_after);
      int guard, t_last;
      boid_t snap;
      dut_sel = sel; cfg_center_en = cen; cfg_match_en = mat;
      self_x = s.x; self_y = s.y; self_vx = s.vx; self_vy = s.vy;
      self_valid = 1;
      guard = 0;
      while (!m_self_ready && guard < 200) begin @(negedge clk); guard++; end
      if (guard >= 200) timeout("self_ready");
      @(negedge clk);
      self_valid = 0;
      t_last = cyc;
      foreach (nbs[i]) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            nb_valid = 0;
            @(negedge clk);
         end
         nb_valid = 1; nb_last = (i == nbs.size() - 1);
         nb_x = nbs[i].x; nb_y = nbs[i].y; nb_vx = nbs[i].vx; nb_vy = nbs[i].vy;
         guard = 0;
         while (!m_nb_ready && guard < 200) begin @(negedge clk); guard++; end
         if (guard >= 200) timeout("nb_ready");
         t_last = cyc;
         @(negedge clk);
      end
      nb_valid = 0; nb_last = 0;
      out_ready = (hold == 0);
      guard = 0;
      while (!m_out_valid && guard < 200) begin @(negedge clk); guard++; end
      if (guard >= 200) timeout("out_valid");
      lat = cyc - t_last;
      snap = {m_out_x, m_out_y, m_out_vx, m_out_vy};
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_stable", {m_out_valid, m_self_ready, m_out_x, m_out_y, m_out_vx, m_out_vy},
             {1'b1, 1'b0, snap.x, snap.y, snap.vx, snap.vy});
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      sr_after = m_self_ready;
      r = snap;
      $display("op sel=%0d n_in=%0d lat=%0d out=(%0h,%0h,%0h,%0h)",
               sel, nbs.size(), lat, r.x, r.y, r.vx, r.vy);
   endtask

   function automatic boid_t mk(input int x, input int y, input int vx, input int vy);
      boid_t b;
      b.x = x; b.y = y; b.vx = vx; b.vy = vy;
      return b;
   endfunction

   // ---------------- test sequence ----------------
   vec_t  vt [4];
   boid_t nbq [$];
   boid_t s, r, e;
   int    lat, n_mod, seen;
   logic  sr;

   initial begin
      // lone boid: only neighbour is itself
      vt[0].s = mk(320*F, 240*F, 5*F, 0); vt[0].n = 1;
      vt[0].nb[0] = mk(320*F, 240*F, 5*F, 0); vt[0].nb[1] = '0; vt[0].nb[2] = '0;
      vt[0].cen = 1; vt[0].mat = 1;
      vt[0].exp = mk(325*F, 240*F, 5*F, 0); vt[0].lat = 4;
      // left-margin turn then boost below VMIN
      vt[1].s = mk(50*F, 240*F, 'h8000, 0); vt[1].n = 1;
      vt[1].nb[0] = mk(50*F, 240*F, 'h8000, 0); vt[1].nb[1] = '0; vt[1].nb[2] = '0;
      vt[1].cen = 1; vt[1].mat = 1;
      vt[1].exp = mk('h32E7FF, 240*F, 'hE7FF, 0); vt[1].lat = 4;
      // cohesion/match: three neighbours at d_sq=400, vx 2,4,6, matching only
      vt[2].s = mk(320*F, 240*F, 6*F, 0); vt[2].n = 3;
      vt[2].nb[0] = mk(300*F, 240*F, 2*F, 0);
      vt[2].nb[1] = mk(340*F, 240*F, 4*F, 0);
      vt[2].nb[2] = mk(320*F, 220*F, 6*F, 0);
      vt[2].cen = 0; vt[2].mat = 1;
      vt[2].exp = mk('h145D334, 240*F, 'h5D334, 0); vt[2].lat = 8'(W + 3);
      // separation: neighbour at dx=3, dy=4 goes to the protected branch
      vt[3].s = mk(320*F, 240*F, 5*F, 0); vt[3].n = 1;
      vt[3].nb[0] = mk(317*F, 236*F, 0, 0); vt[3].nb[1] = '0; vt[3].nb[2] = '0;
      vt[3].cen = 1; vt[3].mat = 1;
      vt[3].exp = mk('h1451332, 'hF01998, 'h51332, 'h1998); vt[3].lat = 4;

      // reset state
      @(negedge clk);
      chk("rst_self_ready", m_self_ready, 0);
      chk("rst_busy", {a_busy, b_busy}, 0);
      chk("rst_out_valid", {a_out_valid, b_out_valid}, 0);
      chk("rst_nb_ready", a_nb_ready, 0);
      chk("rst_out_data", {a_out_x, a_out_y, a_out_vx, a_out_vy}, 0);
      @(negedge clk);
      reset = 0;
      #1;
      chk("post_rst_self_ready", m_self_ready, 1);

      // table vectors
      for (int v = 0; v < 4; v++) begin
         nbq.delete();
         for (int k = 0; k < int'(vt[v].n); k++) nbq.push_back(vt[v].nb[k]);
         run_op(0, vt[v].s, nbq, vt[v].cen, vt[v].mat, 0, 0, r, lat, sr);
         chk($sformatf("vec%0d_x", v), r.x, vt[v].exp.x);
         chk($sformatf("vec%0d_y", v), r.y, vt[v].exp.y);
         chk($sformatf("vec%0d_vx", v), r.vx, vt[v].exp.vx);
         chk($sformatf("vec%0d_vy", v), r.vy, vt[v].exp.vy);
         chk($sformatf("vec%0d_lat", v), lat, vt[v].lat);
         chk($sformatf("vec%0d_self_ready_after", v), sr, 1);
      end

      // counter saturation (CTR_W=2) with output backpressure
      s = mk(320*F, 240*F, 6*F, 0);
      nbq.delete();
      nbq.push_back(mk(300*F, 240*F, 2*F, 0));
      nbq.push_back(mk(340*F, 240*F, 2*F, 0));
      nbq.push_back(mk(320*F, 220*F, 2*F, 0));
      nbq.push_back(mk(320*F, 260*F, 8*F, 0));
      nbq.push_back(mk(300*F, 240*F, 8*F, 0));
      e = model(s, nbq, 3, 0, 1, n_mod);
      run_op(1, s, nbq, 0, 1, 10, 0, r, lat, sr);
      chk("sat_vx", r.vx, e.vx);
      chk("sat_x", r.x, e.x);
      chk("sat_lat", lat, W + 3);
      chk("sat_self_ready_after", sr, 1);

      // reset for two cycles mid-ACCUM
      dut_sel = 0;
      self_x = 320*F; self_y = 240*F; self_vx = 5*F; self_vy = 0;
      self_valid = 1;
      @(negedge clk);
      self_valid = 0;
      nb_valid = 1; nb_last = 0; nb_x = 300*F; nb_y = 240*F; nb_vx = F; nb_vy = 0;
      @(negedge clk);
      chk("midrst_in_accum", {a_busy, a_nb_ready}, 2'b11);
      nb_valid = 0;
      reset = 1;
      @(negedge clk);
      chk("midrst_self_ready_in_reset", a_self_ready, 0);
      chk("midrst_busy_in_reset", a_busy, 0);
      @(negedge clk);
      reset = 0;
      #1;
      chk("midrst_release", {a_self_ready, a_busy, a_out_valid, a_nb_ready}, 4'b1000);
      chk("midrst_out_cleared", {a_out_x, a_out_vx}, 0);
      nb_valid = 1; nb_last = 1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (a_out_valid || a_busy) seen++;
      end
      nb_valid = 0; nb_last = 0;
      chk("midrst_no_output", seen, 0);

      // randomized boids against the reference model
      for (int t = 0; t < 30; t++) begin
         bit cen, mat;
         boid_t b;
         int n_in;
         s = mk(int'($urandom_range(0, 640*F)), int'($urandom_range(0, 480*F)),
                int'($urandom_range(0, 16*F)) - 8*F, int'($urandom_range(0, 16*F)) - 8*F);
         cen = 1'($urandom_range(0, 1));
         mat = 1'($urandom_range(0, 1));
         n_in = $urandom_range(1, 7);
         nbq.delete();
         for (int k = 0; k < n_in; k++) begin
            if ($urandom_range(0, 5) == 0) b = s;
            else b = mk(s.x + int'($urandom_range(0, 90*F)) - 45*F,
                        s.y + int'($urandom_range(0, 90*F)) - 45*F,
                        int'($urandom_range(0, 16*F)) - 8*F,
                        int'($urandom_range(0, 16*F)) - 8*F);
            nbq.push_back(b);
         end
         e = model(s, nbq, 1023, cen, mat, n_mod);
         run_op(0, s, nbq, cen, mat, $urandom_range(0, 2), 1, r, lat, sr);
         chk($sformatf("rnd%0d_x", t), r.x, e.x);
         chk($sformatf("rnd%0d_y", t), r.y, e.y);
         chk($sformatf("rnd%0d_vx", t), r.vx, e.vx);
         chk($sformatf("rnd%0d_vy", t), r.vy, e.vy);
         chk($sformatf("rnd%0d_lat", t), lat, (n_mod == 0) ? 4 : W + 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
